pred_block_collector: RTL and testbench



---
 rtl/pred_pkg.sv | 24 ++
 rtl/pred_round_clip.sv | 38 +++
 rtl/pred_block_collector.sv | 126 ++++++++++++
 tb/tb_pred_block_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pred_pkg
// Description : Shared constants and types for the prediction block collector.
// Revision    : 1.0 - initial release
// ============================================================================
package pred_pkg;

    localparam int IN_W      = 14;  // interpolated sample width (scaled by 2^SHIFT)
    localparam int OUT_W     = 8;   // prediction sample width
    localparam int SHIFT     = 6;   // rounding right-shift
    localparam int ROWS      = 4;   // rows per block, also columns per row
    localparam int TAG_W     = 8;   // block index width
    localparam int NUM_BANKS = 2;   // ping-pong banks

    typedef logic [OUT_W-1:0]            pred_sample_t;
    typedef pred_sample_t [ROWS-1:0]     pred_row_t;    // column c at [c]
    typedef pred_row_t    [ROWS-1:0]     pred_block_t;  // row r at [r]
    typedef logic                        bank_idx_t;
    typedef logic [$clog2(ROWS)-1:0]     row_idx_t;

endpackage
`default_nettype wire

// File: rtl/pred_round_clip.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pred_round_clip
// Description : Round-half-up right shift of one unsigned interpolated sample,
//               saturated to the prediction sample range.
// Revision    : 1.0 - initial release
// ============================================================================
module pred_round_clip
    import pred_pkg::*;
#(
    parameter int SAMPLE_W  = IN_W,
    parameter int PRED_W    = OUT_W,
    parameter int RND_SHIFT = SHIFT
) (
    input  logic [SAMPLE_W-1:0] sample,
    output logic [PRED_W-1:0]   pred
);

    // Half an output LSB, expressed at the input scale.
    localparam logic [SAMPLE_W:0] HALF =
        {{(SAMPLE_W-RND_SHIFT+1){1'b0}}, 1'b1, {(RND_SHIFT-1){1'b0}}};

    logic [SAMPLE_W:0]           sum;
    logic [SAMPLE_W-RND_SHIFT:0] shifted;
    logic [RND_SHIFT-1:0]        unused_low;

    // One extra bit keeps the rounding add from wrapping; saturate on any
    // bit above the output width.
    always_comb begin
        sum        = {1'b0, sample} + HALF;
        shifted    = sum[SAMPLE_W:RND_SHIFT];
        unused_low = sum[RND_SHIFT-1:0];
        pred       = (|shifted[SAMPLE_W-RND_SHIFT:PRED_W]) ? '1 : shifted[PRED_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/pred_block_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pred_block_collector
// Description : Collects four rounded/clipped interpolated rows into a 4x4
//               prediction block using two ping-pong banks and presents each
//               complete block on a valid/ready output with its tag.
// Revision    : 1.0 - initial release
// ============================================================================
module pred_block_collector
    import pred_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_async_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_sample_0,
    input  logic [IN_W-1:0]             in_sample_1,
    input  logic [IN_W-1:0]             in_sample_2,
    input  logic [IN_W-1:0]             in_sample_3,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*ROWS*OUT_W-1:0]  out_block,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        overflow
);

    pred_block_t          bank    [NUM_BANKS];
    logic [NUM_BANKS-1:0] full;
    row_idx_t             row_cnt [NUM_BANKS];
    logic [TAG_W-1:0]     tag_q   [NUM_BANKS];
    bank_idx_t            wr_ptr;
    bank_idx_t            rd_ptr;

    logic [IN_W-1:0]      samples [ROWS];
    pred_row_t            conv_row;
    logic                 accept;
    logic                 out_fire;
    logic                 last_row;

    // Gather the column inputs so the converters can be generated uniformly.
    always_comb begin
        samples[0] = in_sample_0;
        samples[1] = in_sample_1;
        samples[2] = in_sample_2;
        samples[3] = in_sample_3;
    end

    generate
        for (genvar c = 0; c < ROWS; c++) begin : g_col
            pred_round_clip u_round_clip (
                .sample (samples[c]),
                .pred   (conv_row[c])
            );
        end
    endgenerate

    // Handshake decode; ready depends only on registered state.
    always_comb begin
        in_ready  = ~full[wr_ptr];
        out_valid = full[rd_ptr];
        accept    = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        last_row  = (row_cnt[wr_ptr] == row_idx_t'(ROWS-1));
        out_block = bank[rd_ptr];
        out_tag   = tag_q[rd_ptr];
    end

    // Bank storage, fill state and pointers; clear outranks both handshakes.
    // Accept and output handshake always address different banks, so they
    // can update the full flags at the same edge.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank[b]    <= '0;
                row_cnt[b] <= '0;
                tag_q[b]   <= '0;
            end
            full   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (clear) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank[b]    <= '0;
                row_cnt[b] <= '0;
                tag_q[b]   <= '0;
            end
            full   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                bank[wr_ptr][row_cnt[wr_ptr]] <= conv_row;
                if (row_cnt[wr_ptr] == '0) begin
                    tag_q[wr_ptr] <= in_tag;
                end
                if (last_row) begin
                    row_cnt[wr_ptr] <= '0;
                    full[wr_ptr]    <= 1'b1;
                    wr_ptr          <= ~wr_ptr;
                end else begin
                    row_cnt[wr_ptr] <= row_cnt[wr_ptr] + 1'b1;
                end
            end
            if (out_fire) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
    end

    // Sticky flag for rows offered while both banks are occupied.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pred_block_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pred_block_collector
// Description : Directed self-checking bench for pred_block_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pred_block_collector;

    logic         clk = 1'b0;
    logic         rst_async_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [13:0]  in_sample_0, in_sample_1, in_sample_2, in_sample_3;
    logic [7:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic [7:0]   out_tag;
    logic         overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pred_block_collector dut (
        .clk         (clk),
        .rst_async_n (rst_async_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample_0 (in_sample_0),
        .in_sample_1 (in_sample_1),
        .in_sample_2 (in_sample_2),
        .in_sample_3 (in_sample_3),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_block   (out_block),
        .out_tag     (out_tag),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one row whose four samples all round to byte b.
    task automatic row_u(input logic [7:0] b, input logic [7:0] tag);
        in_valid    = 1'b1;
        in_sample_0 = {b, 6'd0};
        in_sample_1 = {b, 6'd0};
        in_sample_2 = {b, 6'd0};
        in_sample_3 = {b, 6'd0};
        in_tag      = tag;
        tick();
    endtask

    task automatic row4(input logic [13:0] s0, input logic [13:0] s1,
                        input logic [13:0] s2, input logic [13:0] s3,
                        input logic [7:0] tag);
        in_valid    = 1'b1;
        in_sample_0 = s0;
        in_sample_1 = s1;
        in_sample_2 = s2;
        in_sample_3 = s3;
        in_tag      = tag;
        tick();
    endtask

    // Block whose row r has every byte equal to the r-th argument.
    function automatic logic [127:0] blk_u(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]   rb [4];
        logic [127:0] blk;
        rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
        blk = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                blk[8*(4*r+c) +: 8] = rb[r];
        return blk;
    endfunction

    task automatic test_reset();
        rst_async_n = 1'b0;
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_tag = 8'h00;
        in_sample_0 = '0; in_sample_1 = '0; in_sample_2 = '0; in_sample_3 = '0;
        tick(); tick();
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_block !== '0)   $display("FAIL reset_out_block: got %h want 0", out_block); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h00)  $display("FAIL reset_out_tag: got %h want 00", out_tag); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0)  $display("FAIL reset_overflow: got %0b want 0", overflow); else pass_cnt++;
        rst_async_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_block();
        out_ready = 1'b1;
        row4(14'd4032, 14'd4032, 14'd4032, 14'd4032, 8'h05);
        row4(14'd4032, 14'd4032, 14'd4032, 14'd4032, 8'hAA);
        row4(14'd4032, 14'd4032, 14'd4032, 14'd4032, 8'hAA);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b want 0", out_valid); else pass_cnt++;
        row4(14'd4032, 14'd4032, 14'd4032, 14'd4032, 8'hAA);
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_block !== {16{8'h3F}}) $display("FAIL basic_block: got %h want %h", out_block, {16{8'h3F}}); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h05)  $display("FAIL basic_tag: got %h want 05", out_tag); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL basic_in_ready: got %0b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_rounding();
        logic [127:0] exp_blk;
        exp_blk = '0;
        exp_blk[0   +: 8] = 8'h00; exp_blk[8   +: 8] = 8'h01; exp_blk[16  +: 8] = 8'hFF; exp_blk[24  +: 8] = 8'hFF;
        exp_blk[32  +: 8] = 8'hFF; exp_blk[40  +: 8] = 8'hFF; exp_blk[48  +: 8] = 8'hFE; exp_blk[56  +: 8] = 8'h00;
        exp_blk[64  +: 8] = 8'h01; exp_blk[72  +: 8] = 8'h01; exp_blk[80  +: 8] = 8'h02; exp_blk[88  +: 8] = 8'h40;
        out_ready = 1'b1;
        row4(14'd31,    14'd32,    14'd16319, 14'd16383, 8'h07);
        row4(14'd16352, 14'd16351, 14'd16287, 14'd0,     8'h99);
        row4(14'd64,    14'd95,    14'd96,    14'd4064,  8'h99);
        row4(14'd0,     14'd0,     14'd0,     14'd0,     8'h99);
        in_valid = 1'b0;
        total_cnt++; if (out_block !== exp_blk) $display("FAIL round_block: got %h want %h", out_block, exp_blk); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h07)     $display("FAIL round_tag: got %h want 07", out_tag); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) row_u(8'(k + 1), (k == 0) ? 8'h01 : 8'hEE);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid: got %0b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL bp_first_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        for (int k = 0; k < 4; k++) row_u(8'(16 + k), (k == 0) ? 8'h02 : 8'hEE);
        total_cnt++; if (in_ready !== 1'b0)  $display("FAIL bp_full_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h01)  $display("FAIL bp_hold_tag: got %h want 01", out_tag); else pass_cnt++;
        total_cnt++; if (out_block !== blk_u(8'h01, 8'h02, 8'h03, 8'h04))
            $display("FAIL bp_hold_block: got %h want %h", out_block, blk_u(8'h01, 8'h02, 8'h03, 8'h04)); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0)  $display("FAIL bp_no_overflow: got %0b want 0", overflow); else pass_cnt++;
        row_u(8'h09, 8'h03);
        in_valid = 1'b0;
        total_cnt++; if (overflow !== 1'b1)  $display("FAIL bp_overflow: got %0b want 1", overflow); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h01)  $display("FAIL bp_tag_after_drop: got %h want 01", out_tag); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_tag !== 8'h02)  $display("FAIL bp_second_tag: got %h want 02", out_tag); else pass_cnt++;
        total_cnt++; if (out_block !== blk_u(8'h10, 8'h11, 8'h12, 8'h13))
            $display("FAIL bp_second_block: got %h want %h", out_block, blk_u(8'h10, 8'h11, 8'h12, 8'h13)); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL bp_ready_return: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid: got %0b want 1", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1)  $display("FAIL bp_overflow_sticky: got %0b want 1", overflow); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) row_u(8'(8'h30 + k), (k == 0) ? 8'h11 : 8'hEE);
        for (int k = 0; k < 3; k++) row_u(8'(8'h40 + k), (k == 0) ? 8'h22 : 8'hEE);
        out_ready = 1'b1;
        row_u(8'h43, 8'hEE);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL sim_valid: got %0b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h22)  $display("FAIL sim_tag: got %h want 22", out_tag); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL sim_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_block !== blk_u(8'h40, 8'h41, 8'h42, 8'h43))
            $display("FAIL sim_block: got %h want %h", out_block, blk_u(8'h40, 8'h41, 8'h42, 8'h43)); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL sim_drained: got %0b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        row_u(8'h05, 8'h33);
        row_u(8'h06, 8'hEE);
        in_valid = 1'b0;
        #2 rst_async_n = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0)  $display("FAIL rst_mid_overflow: got %0b want 0", overflow); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h00)  $display("FAIL rst_mid_tag: got %h want 00", out_tag); else pass_cnt++;
        tick();
        rst_async_n = 1'b1;
        out_ready   = 1'b1;
        for (int k = 0; k < 4; k++) row_u(8'(8'h21 + k), (k == 0) ? 8'h44 : 8'hEE);
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_new_valid: got %0b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h44)  $display("FAIL rst_new_tag: got %h want 44", out_tag); else pass_cnt++;
        total_cnt++; if (out_block !== blk_u(8'h21, 8'h22, 8'h23, 8'h24))
            $display("FAIL rst_new_block: got %h want %h", out_block, blk_u(8'h21, 8'h22, 8'h23, 8'h24)); else pass_cnt++;
        tick();
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) row_u(8'(8'h50 + k), (k == 0) ? 8'h55 : 8'hEE);
        for (int k = 0; k < 2; k++) row_u(8'(8'h60 + k), (k == 0) ? 8'h56 : 8'hEE);
        for (int k = 2; k < 4; k++) row_u(8'(8'h60 + k), 8'hEE);
        row_u(8'h70, 8'h57);
        total_cnt++; if (overflow !== 1'b1)  $display("FAIL clr_pre_overflow: got %0b want 1", overflow); else pass_cnt++;
        clear     = 1'b1;
        out_ready = 1'b1;
        row_u(8'h71, 8'h58);
        clear    = 1'b0;
        in_valid = 1'b0;
        total_cnt++; if (overflow !== 1'b0)  $display("FAIL clr_overflow: got %0b want 0", overflow); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1)  $display("FAIL clr_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_block !== '0)   $display("FAIL clr_out_block: got %h want 0", out_block); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h00)  $display("FAIL clr_out_tag: got %h want 00", out_tag); else pass_cnt++;
        for (int k = 0; k < 4; k++) row_u(8'(8'h31 + k), (k == 0) ? 8'h66 : 8'hEE);
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL clr_new_valid: got %0b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_tag !== 8'h66)  $display("FAIL clr_new_tag: got %h want 66", out_tag); else pass_cnt++;
        total_cnt++; if (out_block !== blk_u(8'h31, 8'h32, 8'h33, 8'h34))
            $display("FAIL clr_new_block: got %h want %h", out_block, blk_u(8'h31, 8'h32, 8'h33, 8'h34)); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_block();
        test_rounding();
        test_backpressure();
        test_simultaneous();
        test_reset_midop();
        test_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
`default_nettype wire
